aes_subbytes_iter: RTL and testbench

AES_SUBBYTES_ITER -- requirements
Module: aes_subbytes_iter

---
 rtl/aes_subbytes_iter.sv | 181 ++++++++++++++++++
 tb/tb_aes_subbytes_iter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_iter.sv
// Iterative AES SubBytes / InvSubBytes over a 128-bit state, LANES S-boxes per cycle.
// Define AES_SUBBYTES_SHIFTROWS_EN to fold (Inv)ShiftRows into the output register.

module aes_sbox (
    input  logic [7:0] data_in,
    input  logic       enc_dec,
    output logic [7:0] data_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
    endfunction

    logic [7:0] inv_aff;
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] fwd_aff;

    always_comb begin
        inv_aff  = {data_in[6:0], data_in[7]} ^ {data_in[4:0], data_in[7:5]} ^
                   {data_in[1:0], data_in[7:2]} ^ 8'h05;
        inv_in   = enc_dec ? data_in : inv_aff;
        inv_out  = gf_inv(inv_in);
        fwd_aff  = inv_out ^ {inv_out[6:0], inv_out[7]} ^ {inv_out[5:0], inv_out[7:6]} ^
                   {inv_out[4:0], inv_out[7:5]} ^ {inv_out[3:0], inv_out[7:4]} ^ 8'h63;
        data_out = enc_dec ? fwd_aff : inv_out;
    end

endmodule

module aes_subbytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         enc_dec,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and ready/valid here come straight from state flops.

    localparam int         PASSES   = 16 / LANES;
    localparam logic [1:0] LAST_CNT = 2'(PASSES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             enc_q, enc_d;
    logic [15:0][7:0] data_q, data_d;
    logic [15:0][7:0] out_q, out_d;
    logic [15:0][7:0] next_data;

    logic [3:0] lane_idx [LANES];
    logic [7:0] sbox_in  [LANES];
    logic [7:0] sbox_out [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .data_in  (sbox_in[g]),
            .enc_dec  (enc_q),
            .data_out (sbox_out[g])
        );
    end

`ifdef AES_SUBBYTES_SHIFTROWS_EN
    // Byte k sits at packed index 15-k with row k%4, column k/4.
    function automatic logic [15:0][7:0] shift_rows(input logic [15:0][7:0] s, input logic enc);
        logic [15:0][7:0] r;
        int src_col;
        r = s;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src_col = enc ? ((c + row) % 4) : ((c - row + 4) % 4);
                r[15 - (4 * c + row)] = s[15 - (4 * src_col + row)];
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
            sbox_in[l]  = data_q[4'd15 - lane_idx[l]];
        end
        next_data = data_q;
        for (int l = 0; l < LANES; l++) begin
            next_data[4'd15 - lane_idx[l]] = sbox_out[l];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        data_d  = data_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = state_in;
                    enc_d   = enc_dec;
                    cnt_d   = 2'd0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                data_d = next_data;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_HOLD;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
                    out_d   = shift_rows(next_data, enc_q);
`else
                    out_d   = next_data;
`endif
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            enc_q   <= 1'b0;
            data_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            data_q  <= data_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_SUB) || (state_q == S_HOLD);
    assign state_out = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_subbytes_iter.sv
// Directed bench for aes_subbytes_iter: a LANES=4 and a LANES=16 instance side by side.

module tb_aes_subbytes_iter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic         iv4 = 1'b0, ir4, ed4 = 1'b0, ov4, or4 = 1'b0, busy4;
    logic [127:0] si4 = '0, so4;
    logic [1:0]   st4;
    logic         iv16 = 1'b0, ir16, ed16 = 1'b0, ov16, or16 = 1'b0, busy16;
    logic [127:0] si16 = '0, so16;
    logic [1:0]   st16;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] ZERO    = 128'h0;
    localparam logic [127:0] ALL63   = {16{8'h63}};
    localparam logic [127:0] FIPS_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    localparam logic [127:0] FIPS_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
    localparam logic [127:0] FIPS_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif

    aes_subbytes_iter #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .enc_dec(ed4),
        .state_in(si4), .out_valid(ov4), .out_ready(or4), .state_out(so4),
        .busy(busy4), .dbg_state(st4)
    );

    aes_subbytes_iter #(.LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .enc_dec(ed16),
        .state_in(si16), .out_valid(ov16), .out_ready(or16), .state_out(so16),
        .busy(busy16), .dbg_state(st16)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one state, scramble the inputs right after the accept edge, wait for out_valid.
    task automatic xfer(input bit use16, input bit enc, input logic [127:0] x,
                        output logic [127:0] y, output int lat,
                        output logic busy_acc, output logic rdy_acc);
        @(negedge clk);
        if (use16) begin si16 = x; ed16 = enc; iv16 = 1'b1; end
        else       begin si4  = x; ed4  = enc; iv4  = 1'b1; end
        @(posedge clk); #1;
        busy_acc = use16 ? busy16 : busy4;
        rdy_acc  = use16 ? ir16 : ir4;
        if (use16) begin iv16 = 1'b0; si16 = ~x; ed16 = ~enc; end
        else       begin iv4  = 1'b0; si4  = ~x; ed4  = ~enc; end
        lat = 0;
        while (((use16 ? ov16 : ov4) !== 1'b1) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        y = use16 ? so16 : so4;
    endtask

    task automatic consume(input bit use16);
        @(negedge clk);
        if (use16) or16 = 1'b1; else or4 = 1'b1;
        @(posedge clk); #1;
        if (use16) or16 = 1'b0; else or4 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (ov4 !== 1'b0 || so4 !== ZERO || busy4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_l4: ov=%b busy=%b out=%h, want 0 0 0", ov4, busy4, so4);
        end
        tests_run++;
        if (ov16 !== 1'b0 || so16 !== ZERO || busy16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_l16: ov=%b busy=%b out=%h, want 0 0 0", ov16, busy16, so16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (ir4 !== 1'b1 || ir16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: in_ready l4=%b l16=%b, want 1 1", ir4, ir16);
        end
    endtask

    task automatic test_enc_zero;
        logic [127:0] y; int lat; logic b, r;
        xfer(0, 1'b1, ZERO, y, lat, b, r);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL enc_zero_latency: got %0d want 4", lat); end
        tests_run++;
        if (y !== ALL63) begin tests_failed++; $display("FAIL enc_zero_data: got %h want %h", y, ALL63); end
        tests_run++;
        if (b !== 1'b1 || r !== 1'b0) begin
            tests_failed++;
            $display("FAIL enc_zero_sub_flags: busy=%b in_ready=%b, want 1 0", b, r);
        end
        consume(0);
        tests_run++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL enc_zero_release: out_valid=%b in_ready=%b, want 0 1", ov4, ir4);
        end
    endtask

    task automatic test_fips_vector;
        logic [127:0] y; int lat; logic b, r;
        xfer(0, 1'b1, FIPS_IN, y, lat, b, r);
        tests_run++;
        if (y !== FIPS_EXP || lat !== 4) begin
            tests_failed++;
            $display("FAIL fips_enc: got %h lat %0d want %h lat 4", y, lat, FIPS_EXP);
        end
        consume(0);
    endtask

    task automatic test_dec;
        logic [127:0] y; int lat; logic b, r;
        xfer(0, 1'b0, ALL63, y, lat, b, r);
        tests_run++;
        if (y !== ZERO) begin tests_failed++; $display("FAIL dec_63: got %h want %h", y, ZERO); end
        consume(0);
        xfer(0, 1'b0, FIPS_EXP, y, lat, b, r);
        tests_run++;
        if (y !== FIPS_IN) begin tests_failed++; $display("FAIL dec_fips: got %h want %h", y, FIPS_IN); end
        consume(0);
    endtask

    task automatic test_round_trip;
        logic [127:0] x, y, z; int lat; logic b, r;
        for (int i = 0; i < 16; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            xfer(0, 1'b1, x, y, lat, b, r);
            consume(0);
            xfer(0, 1'b0, y, z, lat, b, r);
            consume(0);
            tests_run++;
            if (z !== x) begin
                tests_failed++;
                $display("FAIL round_trip_%0d: got %h want %h", i, z, x);
            end
        end
    endtask

    task automatic test_out_ready_early;
        logic [127:0] y; int lat; logic b, r;
        @(negedge clk);
        or4 = 1'b1;
        xfer(0, 1'b1, FIPS_IN, y, lat, b, r);
        tests_run++;
        if (y !== FIPS_EXP || lat !== 4) begin
            tests_failed++;
            $display("FAIL early_ready: got %h lat %0d want %h lat 4", y, lat, FIPS_EXP);
        end
        @(posedge clk); #1;
        or4 = 1'b0;
        tests_run++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL early_ready_release: out_valid=%b in_ready=%b, want 0 1", ov4, ir4);
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] y; int lat; logic b, r; int bad;
        xfer(0, 1'b1, FIPS_IN, y, lat, b, r);
        @(negedge clk);
        si4 = ALL63; ed4 = 1'b0; iv4 = 1'b1; or4 = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (so4 !== FIPS_EXP || ir4 !== 1'b0 || ov4 !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: %0d bad cycles, last out=%h want %h", bad, so4, FIPS_EXP);
        end
        @(negedge clk);
        or4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; or4 = 1'b0;
        tests_run++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", ov4, ir4);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_no_capture: busy=%b want 0", busy4);
        end
    endtask

    task automatic test_reset_abort;
        logic [127:0] y; int lat; logic b, r; int seen;
        @(negedge clk);
        si4 = ALL63; ed4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ov4 !== 1'b0 || so4 !== ZERO || busy4 !== 1'b0 || ir4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_clear: ov=%b busy=%b rdy=%b out=%h, want 0 0 1 0", ov4, busy4, ir4, so4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ov4 !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL abort_no_pulse: out_valid seen %0d cycles, want 0", seen);
        end
        xfer(0, 1'b1, FIPS_IN, y, lat, b, r);
        tests_run++;
        if (y !== FIPS_EXP || lat !== 4) begin
            tests_failed++;
            $display("FAIL abort_next: got %h lat %0d want %h lat 4", y, lat, FIPS_EXP);
        end
        consume(0);
    endtask

    task automatic test_lanes16;
        logic [127:0] y; int lat; logic b, r;
        xfer(1, 1'b1, ZERO, y, lat, b, r);
        tests_run++;
        if (y !== ALL63 || lat !== 1) begin
            tests_failed++;
            $display("FAIL l16_zero: got %h lat %0d want %h lat 1", y, lat, ALL63);
        end
        consume(1);
        xfer(1, 1'b1, FIPS_IN, y, lat, b, r);
        tests_run++;
        if (y !== FIPS_EXP || lat !== 1) begin
            tests_failed++;
            $display("FAIL l16_fips: got %h lat %0d want %h lat 1", y, lat, FIPS_EXP);
        end
        consume(1);
        xfer(1, 1'b0, FIPS_EXP, y, lat, b, r);
        tests_run++;
        if (y !== FIPS_IN || lat !== 1) begin
            tests_failed++;
            $display("FAIL l16_dec: got %h lat %0d want %h lat 1", y, lat, FIPS_IN);
        end
        consume(1);
    endtask

    initial begin
        test_reset();
        test_enc_zero();
        test_fips_vector();
        test_dec();
        test_round_trip();
        test_out_ready_early();
        test_backpressure();
        test_reset_abort();
        test_lanes16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
